// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns a latched EXE/MEM instruction into a
// req/ack data-memory transaction and returns a registered result toward MEM/WB.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_pass,
  input  logic        flush,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_exc
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << lo;
      2'b01:   r = lo[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lo,
                                          input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pass_q, pass_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, lo_q, lo_d;
  logic        uns_q, uns_d, load_q, load_d, kill_q, kill_d;
  logic        out_valid_q, out_valid_d, out_exc_q, out_exc_d;
  logic [31:0] out_data_q, out_data_d;
  logic        mem_op_s, mis_s, stall_s;

  always_comb begin
    mem_op_s    = in_valid & (in_load | in_store) & ~flush;
    mis_s       = is_misaligned(in_size, in_addr[1:0]);
    stall_s     = 1'b0;
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    lo_d        = lo_q;
    uns_d       = uns_q;
    load_d      = load_q;
    pass_d      = pass_q;
    kill_d      = kill_q;
    out_valid_d = 1'b0;
    out_exc_d   = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (mem_op_s && !mis_s) begin
          stall_s = 1'b1;
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = in_store;
          addr_d  = {in_addr[31:2], 2'b00};
          be_d    = lane_enable(in_size, in_addr[1:0]);
          wdata_d = lane_data(in_size, in_wdata);
          size_d  = in_size;
          lo_d    = in_addr[1:0];
          uns_d   = in_unsigned;
          load_d  = in_load;
          pass_d  = in_pass;
        end else if (mem_op_s) begin
          out_valid_d = 1'b1;
          out_exc_d   = 1'b1;
          out_data_d  = in_addr;
        end else if (in_valid && !flush) begin
          out_valid_d = 1'b1;
          out_data_d  = in_pass;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      WAIT: begin
        stall_s = ~mem_ack;
        // A flush seen in any WAIT cycle only suppresses the result; the bus access still finishes.
        if (mem_ack) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          out_valid_d = ~(kill_q | flush);
          out_data_d  = load_q ? extract(size_q, lo_q, uns_q, mem_rdata) : pass_q;
        end else begin
          kill_d = kill_q | flush;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      pass_q      <= 32'h0000_0000;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_exc_q   <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      uns_q       <= uns_d;
      load_q      <= load_d;
      pass_q      <= pass_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_exc_q   <= out_exc_d;
      out_data_q  <= out_data_d;
    end
  end

  // Stall must read low while reset is held, whatever the upstream inputs show.
  assign stall     = stall_s & rst_n;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_exc   = out_exc_q;

endmodule
